// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, bit timing default and
// the character set used on the host/XBee command link.
package uart_pkg;

  // 50 MHz system clock / 115200 baud; the transmitter uses the same value.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [7:0] HASH   = 8'h23;  // end of message
  localparam logic [7:0] DASH   = 8'h2D;
  localparam logic [7:0] CHAR_A = 8'h41;
  localparam logic [7:0] CHAR_C = 8'h43;
  localparam logic [7:0] CHAR_F = 8'h46;
  localparam logic [7:0] CHAR_I = 8'h49;
  localparam logic [7:0] CHAR_S = 8'h53;
  localparam logic [7:0] CHAR_T = 8'h54;
  localparam logic [7:0] CHAR_W = 8'h57;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; clears to 0 on a
// synchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: non-blocking assignment so both stages shift on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte register, end-of-
// message flag, one-cycle framing-error and overrun pulses.
module uart_receive
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0]  EOM_CHAR     = HASH
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       I_RX_SERIAL,
  input  logic       I_RX_READY,
  output logic [7:0] O_RX_BYTE,
  output logic       O_RX_VALID,
  output logic       O_RX_EOM,
  output logic       O_FRAME_ERR,
  output logic       O_OVERRUN,
  output logic       O_BUSY
);

  localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_BIT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             rx_eom_q;
  logic             frame_err_q;
  logic             overrun_q;

  sync_2ff u_sync (
    .clk_i (CLOCK),
    .rst_i (RESET),
    .d_i   (I_RX_SERIAL),
    .q_o   (rx)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= ST_WAIT_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_eom_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: defaults first; a load in STOP below overrides the valid clear.
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (rx_valid_q && I_RX_READY) begin
        rx_valid_q <= 1'b0;
      end

      unique case (state_q)
        // A full bit time of continuous idle is needed to trust the line.
        ST_WAIT_IDLE: begin
          if (!rx) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_BIT) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_IDLE: begin
          if (!rx) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            state_q <= rx ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx;
            bit_idx_q          <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q <= '0;
            if (rx) begin
              if (!rx_valid_q || I_RX_READY) begin
                rx_byte_q  <= shift_q;
                rx_eom_q   <= (shift_q == EOM_CHAR);
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_IDLE;
        end
      endcase
    end
  end

  assign O_RX_BYTE   = rx_byte_q;
  assign O_RX_VALID  = rx_valid_q;
  assign O_RX_EOM    = rx_eom_q;
  assign O_FRAME_ERR = frame_err_q;
  assign O_OVERRUN   = overrun_q;
  assign O_BUSY      = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

endmodule
